// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: one 2^k shift stage per register, valid/ready
// handshake with a global stall, and a registered result stage.
//
// Ports:
//   Clk, Rst            clock, synchronous active-high reset
//   a, sh_amt, mode     operand, unsigned shift amount, operation
//                       (00 lsr, 01 asr, 10 lsl, 11 ror)
//   in_valid/in_ready   input handshake
//   d, ovr              registered result and "sh_amt >= DATAWIDTH" flag
//   out_valid/out_ready output handshake
module pipelined_shifter #(
    parameter int DATAWIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] sh_amt,
    input  logic [1:0]           mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [DATAWIDTH-1:0] d,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 ovr
);

    localparam int W = DATAWIDTH;
    localparam int L = $clog2(DATAWIDTH);

    localparam logic [1:0] M_LSR = 2'b00;
    localparam logic [1:0] M_ASR = 2'b01;
    localparam logic [1:0] M_LSL = 2'b10;
    localparam logic [1:0] M_ROR = 2'b11;

    logic adv;

    // The whole pipe moves together; it only stops when the result
    // register holds an unconsumed value.
    assign in_ready = !out_valid || out_ready;
    assign adv      = in_ready;

    function automatic logic [W-1:0] shift_by(
        input logic [W-1:0] x,
        input logic [1:0]   m,
        input logic         s,
        input int           n
    );
        logic [2*W-1:0] ext;
        ext      = '0;
        shift_by = x;
        case (m)
            M_LSR: shift_by = x >> n;
            M_ASR: begin
                // s is the sign of the original operand, not of x
                ext      = {{W{s}}, x} >> n;
                shift_by = ext[W-1:0];
            end
            M_LSL: shift_by = x << n;
            default: shift_by = (x >> n) | (x << (W - n));
        endcase
    endfunction

    for (genvar k = 0; k < L; k++) begin : g_st
        localparam int SH = 1 << k;

        // amt_in holds the amount bits not yet consumed: bit 0 is this stage
        logic [L-1-k:0] amt_in;
        logic [W-1:0]   dat_in;
        logic [1:0]     md_in;
        logic           sg_in;
        logic           ov_in;
        logic           vl_in;

        logic [W-1:0]   dat;
        logic [1:0]     md;
        logic           sg;
        logic           ov;
        logic           vl;

        if (k == 0) begin : g_src
            assign amt_in = sh_amt[L-1:0];
            assign dat_in = a;
            assign md_in  = mode;
            assign sg_in  = a[W-1];
            assign ov_in  = |sh_amt[W-1:L];
            assign vl_in  = in_valid;
        end else begin : g_src
            assign amt_in = g_st[k-1].g_rem.rem;
            assign dat_in = g_st[k-1].dat;
            assign md_in  = g_st[k-1].md;
            assign sg_in  = g_st[k-1].sg;
            assign ov_in  = g_st[k-1].ov;
            assign vl_in  = g_st[k-1].vl;
        end

        if (k < L - 1) begin : g_rem
            logic [L-2-k:0] rem;
            always_ff @(posedge Clk) begin
                if (Rst) begin
                    rem <= '0;
                end else if (adv) begin
                    rem <= amt_in[L-1-k:1];
                end
            end
        end

        always_ff @(posedge Clk) begin
            if (Rst) begin
                dat <= '0;
                md  <= '0;
                sg  <= 1'b0;
                ov  <= 1'b0;
                vl  <= 1'b0;
            end else if (adv) begin
                dat <= amt_in[0] ? shift_by(dat_in, md_in, sg_in, SH)
                                 : dat_in;
                md  <= md_in;
                sg  <= sg_in;
                ov  <= ov_in;
                vl  <= vl_in;
            end
        end
    end

    // Overrange replaces the low-bit shift result except for rotate,
    // where the amount is taken modulo the width.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            out_valid <= 1'b0;
            d         <= '0;
            ovr       <= 1'b0;
        end else if (adv) begin
            out_valid <= g_st[L-1].vl;
            ovr       <= g_st[L-1].ov;
            if (g_st[L-1].ov && g_st[L-1].md != M_ROR) begin
                d <= (g_st[L-1].md == M_ASR) ? {W{g_st[L-1].sg}} : '0;
            end else begin
                d <= g_st[L-1].dat;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Self-checking bench for pipelined_shifter (DATAWIDTH=16): directed
// vectors with literal results plus a queue-based reference model.
module tb_pipelined_shifter;

    localparam int W = 16;
    localparam int L = 4;

    logic         Clk = 1'b0;
    logic         Rst;
    logic [W-1:0] a;
    logic [W-1:0] sh_amt;
    logic [1:0]   mode;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] d;
    logic         out_valid;
    logic         out_ready;
    logic         ovr;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] r;
        logic         o;
    } exp_t;

    exp_t q[$];

    always #5 Clk = ~Clk;

    pipelined_shifter #(.DATAWIDTH(W)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .a         (a),
        .sh_amt    (sh_amt),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovr       (ovr)
    );

    function automatic exp_t model(input logic [W-1:0] x,
                                   input logic [W-1:0] sh,
                                   input logic [1:0] m);
        exp_t e;
        int   n;
        e.o = (sh >= W);
        n   = int'(sh) % W;
        case (m)
            2'd0: e.r = e.o ? '0 : x >> n;
            2'd1: e.r = e.o ? {W{x[W-1]}} : W'($signed(x) >>> n);
            2'd2: e.r = e.o ? '0 : x << n;
            default: e.r = W'({x, x} >> n);
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Scoreboard: handshakes are decided by the values stable at negedge.
    initial begin : compare
        exp_t        e;
        logic [W-1:0] hd;
        logic        ho;
        bit          stalled;
        stalled = 0;
        hd = '0;
        ho = 1'b0;
        forever begin
            @(negedge Clk);
            if (Rst) begin
                q.delete();
                stalled = 0;
            end else if (!$isunknown(out_valid)) begin
                chk("in_ready_rule", in_ready, !out_valid || out_ready);
                if (stalled) begin
                    chk("hold_d", d, hd);
                    chk("hold_ovr", ovr, ho);
                end
                if (in_valid && in_ready)
                    q.push_back(model(a, sh_amt, mode));
                if (out_valid && out_ready) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_result: got d=%h none expected", d);
                    end else begin
                        e = q.pop_front();
                        chk("model_d", d, e.r);
                        chk("model_ovr", ovr, e.o);
                    end
                end
                stalled = out_valid && !out_ready;
                hd = d;
                ho = ovr;
            end
        end
    end

    task automatic directed4(input string tag,
                             input logic [W-1:0] av, input logic [W-1:0] sv,
                             input logic [W-1:0] e0, input logic [W-1:0] e1,
                             input logic [W-1:0] e2, input logic [W-1:0] e3,
                             input logic eo);
        logic [W-1:0] ex[4];
        ex = '{e0, e1, e2, e3};
        out_ready = 1'b1;
        for (int m = 0; m < 4; m++) begin
            a        = av;
            sh_amt   = sv;
            mode     = 2'(m);
            in_valid = 1'b1;
            #1;
            chk({tag, "_in_ready"}, in_ready, 1);
            step();
        end
        in_valid = 1'b0;
        for (int m = 0; m < 4; m++) begin
            step();
            chk({tag, "_out_valid"}, out_valid, 1);
            chk({tag, "_d"}, d, ex[m]);
            chk({tag, "_ovr"}, ovr, eo);
        end
        repeat (4) step();
    endtask

    initial begin : main
        int i;
        int acc;
        int cyc;

        Rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        sh_amt    = '0;
        mode      = '0;
        out_ready = 1'b1;
        step();
        step();
        Rst       = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_d", d, 0);
        chk("reset_ovr", ovr, 0);
        chk("reset_in_ready", in_ready, 1);
        out_ready = 1'b1;

        directed4("basic", 16'h8013, 16'd4,
                  16'h0801, 16'hF801, 16'h0130, 16'h3801, 1'b0);
        directed4("overrange", 16'h8013, 16'd20,
                  16'h0000, 16'hFFFF, 16'h0000, 16'h3801, 1'b1);
        directed4("zero_amt", 16'hA5A5, 16'd0,
                  16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 1'b0);

        // eight back-to-back inputs, consumer stalls three cycles
        i = 0;
        for (int c = 0; c < 24; c++) begin
            in_valid  = (i < 8);
            a         = 16'(32'h1357 * (i + 1));
            sh_amt    = 16'(i * 3);
            mode      = 2'(i);
            out_ready = !(c >= 6 && c < 9);
            #1;
            if (c >= 6 && c < 9)
                chk("stall_in_ready", in_ready, 0);
            if (in_valid && in_ready)
                i++;
            step();
        end
        chk("stall_accepted", i, 8);
        chk("stall_drained", q.size(), 0);

        // reset with three results in flight
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a        = 16'(16'h0F0F + k);
            sh_amt   = 16'd1;
            mode     = 2'd2;
            in_valid = 1'b1;
            step();
        end
        Rst = 1'b1;
        step();
        Rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_d", d, 0);
        chk("flush_in_ready", in_ready, 1);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("flush_no_result", out_valid, 0);
        end

        // random handshakes against the model
        acc = 0;
        cyc = 0;
        while (acc < 10000 && cyc < 60000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a         = 16'($urandom);
            sh_amt    = ($urandom_range(0, 7) == 0) ? 16'($urandom)
                                                    : 16'($urandom_range(0, 20));
            mode      = 2'($urandom);
            #1;
            if (in_valid && in_ready)
                acc++;
            step();
            cyc++;
        end
        chk("random_accepts", acc, 10000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) step();
        chk("final_queue_empty", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_shifter.md
PIPELINED_SHIFTER -- requirements
Module: pipelined_shifter

Interface
REQ-001 Parameter DATAWIDTH, default 16, operand/result width; SHALL be a power of two in 8..64.
REQ-002 Parameter L, fixed at log2(DATAWIDTH), not overridable; pipeline depth in cycles.
REQ-003 Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Rst  input  1  reset, synchronous and active-high.
REQ-005 a  input  DATAWIDTH  operand.
REQ-006 sh_amt  input  DATAWIDTH  shift amount, unsigned.
REQ-007 mode  input  2  00 logical right, 01 arithmetic right, 10 logical left, 11 rotate right.
REQ-008 in_valid  input  1  a/sh_amt/mode valid this cycle.
REQ-009 in_ready  output  1  block can accept input this cycle.
REQ-010 d  output  DATAWIDTH  registered result.
REQ-011 out_valid  output  1  d holds a valid result.
REQ-012 out_ready  input  1  consumer accepts d this cycle.
REQ-013 ovr  output  1  registered; set with d when the result's sh_amt was >= DATAWIDTH.

Function
REQ-014 Input accepted on a rising edge where in_valid and in_ready are both 1; output consumed where out_valid and out_ready are both 1.
REQ-015 Pipeline of L register stages; stage k (k=0..L-1) applies a shift of 2^k when bit k of the effective amount is 1, else passes the data through.
REQ-016 Each stage carries a valid bit, the data, mode, the overrange flag and the remaining amount bits.
REQ-017 Effective amount for rotate = sh_amt mod DATAWIDTH (low L bits); overrange flag still set if sh_amt >= DATAWIDTH.
REQ-018 Overrange, non-rotate modes: result SHALL be 0 for logical right/left, and all bits = a[DATAWIDTH-1] for arithmetic right.
REQ-019 Arithmetic right fills vacated bits with the original a[DATAWIDTH-1], carried through every stage.
REQ-020 Latency: a result accepted in cycle N SHALL appear on d with out_valid=1 after edge N+L when no stall occurs.
REQ-021 Throughput: one result per cycle while out_ready=1.
REQ-022 Stall: in_ready = !out_valid | out_ready; when in_ready=0 every stage register, including d/ovr/out_valid, holds its value.
REQ-023 While out_valid=1 and out_ready=0, d and ovr SHALL remain stable until consumption.
REQ-024 Bubbles (stage valid=0) advance like data when not stalled; only valid entries raise out_valid.
REQ-025 Results SHALL leave in acceptance order; no drop and no duplication under any in_valid/out_ready pattern.
REQ-026 Simultaneous accept and consume in one cycle is legal and SHALL neither lose nor repeat data.
REQ-027 in_valid while in_ready=0: the input is not captured; the source must hold it.
REQ-028 sh_amt = 0: d = a in every mode, ovr=0.

Reset
REQ-029 Rst=1 at a rising edge clears all stage valid bits; out_valid=0, d=0, ovr=0 on the next cycle.
REQ-030 Rst overrides any handshake in the same cycle; in-flight results are discarded, not completed.
REQ-031 in_ready SHALL be 1 in the first cycle after Rst deasserts.

Verification (DATAWIDTH=16, L=4, out_ready=1 unless stated)
REQ-032 a=16'h8013, sh_amt=4, modes 00/01/10/11 on consecutive cycles -> d=16'h0801, 16'hF801, 16'h0130, 16'h3801 on four consecutive cycles starting 4 cycles after the first accept; ovr=0.
REQ-033 a=16'h8013, sh_amt=20, modes 00/01/10/11 -> d=16'h0000, 16'hFFFF, 16'h0000, 16'h3801; ovr=1 on each.
REQ-034 Stream 8 inputs back to back with out_ready low for 3 cycles mid-stream -> in_ready=0 for those cycles, d frozen, all 8 results in order, none lost.
REQ-035 Rst asserted for one cycle with 3 results in flight -> out_valid=0 next cycle, none of the 3 ever appears, in_ready=1 after release.
REQ-036 sh_amt=0 with a=16'hA5A5 in all modes -> d=16'hA5A5, ovr=0.
REQ-037 Random in_valid/out_ready, 10k transactions vs. reference model -> zero mismatches, no ordering or count errors.
